cc3_irq_ctrl: RTL and testbench
===============================

# cc3_irq_ctrl

Interrupt controller feeding the MC6809 core's `cpu_irq_n`, `cpu_firq_n` and `cpu_nmi_n` inputs.
- Collects eight peripheral interrupt sources plus one NMI source, with an optional periodic timer.
- Latches pending events and applies separate IRQ and FIRQ enable masks.
- Exposes a byte-wide register window on the CPU bus, so firmware can read status and acknowledge events.
- Sits beside the boot RAM on the CPU bus; the top level muxes its read data onto `cpu_data_i` when `sel_o` is high.

## Interface
Parameters:
- BASE_ADDR, 16'hFF90: base of the 8-byte register window; bits [2:0] must be 0.
- NMI_PULSE_CYCLES, 4: number of cycles `cpu_nmi_n` is held low per NMI event; must be ≥1.

Ports:
- clk32_i  in  1  system clock; the single clock of the block.
- cpu_reset  in  1  synchronous, active-high reset.
- cpu_addr_i  in  16  CPU address.
- cpu_data_i  in  8  CPU write data.
- cpu_we_i  in  1  write strobe, active-high.
- cpu_oe_i  in  1  read strobe, active-high.
- cpu_data_o  out  8  read data, registered.
- sel_o  out  1  high when `cpu_data_o` carries this block's read data.
- irq_src_i  in  8  asynchronous interrupt sources, active-high.
- nmi_src_i  in  1  asynchronous NMI source, active-high.
- cpu_irq_n  out  1  IRQ request to the CPU, active-low, registered.
- cpu_firq_n  out  1  FIRQ request to the CPU, active-low, registered.
- cpu_nmi_n  out  1  NMI request to the CPU, active-low, registered.

## Operation
Source conditioning:
- Every source passes through a 2-flop synchronizer, then a prior-value flop used for edge detection.

Register map (offset from BASE_ADDR; all registers reset to 0):
- +0 PEND: read returns the pending bits. Write 1 clears that bit (W1C), edge-mode bits only.
- +1 IRQ_EN, +2 FIRQ_EN, +3 EDGE: read/write. EDGE bit 1 = rising-edge mode; 0 = level mode.
- +4 TMR_LO, +5 TMR_HI: 16-bit timer reload value, read/write.
- +6 TMR_CTL: bit0 = RUN. Bits [7:1] read as 0.
- +7 NMI_CTL: bit0 = ARM. Writing 1 sets ARM; writing 0 has no effect; only reset clears it. Bits [7:1] read as 0.

Pending logic:
- Level-mode bit: PEND[i] equals the synchronized level every cycle; W1C has no effect.
- Edge-mode bit: a detected rising edge sets PEND[i]. If a set and a W1C hit the same bit in the same cycle, the set wins.
- Switching a bit from level to edge mode clears that PEND bit in the same cycle.

Request outputs:
- `cpu_irq_n` = ~|(PEND & IRQ_EN), registered.
- `cpu_firq_n` = ~|(PEND & FIRQ_EN), registered. One source may drive both.

NMI:
- Events are ignored while ARM=0.
- A synchronized rising edge of `nmi_src_i` drives `cpu_nmi_n` low for exactly NMI_PULSE_CYCLES cycles.
- Edges that arrive while a pulse is in progress are dropped.

Bus access:
- A bus access is any cycle with `cpu_addr_i[15:3]` == BASE_ADDR[15:3] and `cpu_we_i` or `cpu_oe_i` high.
- If `cpu_we_i` and `cpu_oe_i` are both high in the same cycle, the write is performed and the read is still returned.
- Out-of-window reads leave `cpu_data_o` at 0 and `sel_o` low.

## Timing
- Reset, effective on the next edge: all registers, synchronizers, the timer and the NMI pulse counter go to 0. `cpu_irq_n`, `cpu_firq_n` and `cpu_nmi_n` go to 1; `cpu_data_o` and `sel_o` go to 0.
- Reset asserted mid-pulse aborts the pulse: `cpu_nmi_n` is 1 after that edge.
- Source first sampled high at edge 0: PEND is readable after edge 2 and `cpu_irq_n`/`cpu_firq_n` go low after edge 3. The same 3-edge latency applies to the start of an NMI pulse.
- Read: address and `cpu_oe_i` sampled at edge k; `cpu_data_o` and `sel_o` are valid after edge k, for one cycle. This matches the boot RAM's one-cycle read latency.
- Write: takes effect at the sampling edge. The request outputs reflect the write one edge later.
- Timer (CC3_IRQ_TIMER_EN):
  - 16-bit down-counter, loaded from the reload value when RUN goes 0→1.
  - On reaching 0 it sets PEND[7] for one cycle's event and reloads, giving a period of reload+1 cycles.
  - Reload = 0 halts the timer: no events.
  - Reload writes made while running take effect at the next reload.
  - RUN=0 freezes the counter.

## Configuration
- CC3_IRQ_TIMER_EN defined: timer present; PEND[7] = OR of irq_src_i[7] events and timer events. Bit 7's EDGE setting governs only irq_src_i[7]; timer events always latch.
- CC3_IRQ_TIMER_EN undefined: no timer logic; offsets +4..+6 read 0 and ignore writes; PEND[7] comes from irq_src_i[7] only.

## Structure
- Package cc3_irq_pkg: register offset constants, register reset values, the source count (8) and the timer width (16).
- Sub-module cc3_irq_timer: counter, reload and event pulse. Instantiated only under CC3_IRQ_TIMER_EN.

## Test plan
- Reset, then read all 8 offsets: every read returns 8'h00; `cpu_irq_n`, `cpu_firq_n` and `cpu_nmi_n` are 1.
- Level IRQ: write IRQ_EN=8'h01, pulse irq_src_i[0] high for 10 cycles → `cpu_irq_n` low 3 edges after the rise and high 3 edges after the fall; `cpu_firq_n` stays 1.
- Edge FIRQ:
  - Write EDGE=8'h04 and FIRQ_EN=8'h04, then give irq_src_i[2] a 1-cycle pulse → PEND reads 8'h04 and `cpu_firq_n` stays low.
  - Write 8'h04 to PEND → `cpu_firq_n` returns to 1 one edge later.
  - W1C in the same cycle as a new edge → PEND stays 8'h04.
- NMI:
  - nmi_src_i edge with ARM=0 → no pulse.
  - Write NMI_CTL=1, then one edge → `cpu_nmi_n` low for exactly 4 cycles.
  - A second edge during the pulse → ignored.
- Timer:
  - Reload=16'd9, EDGE[7]=1, RUN=1 → PEND[7] set every 10 cycles; clear it with W1C between events.
  - Reload=0 → no events.
  - Without the macro, offset +4 reads 0 after writing 8'hFF.
- Bus: read at BASE_ADDR+8 → `sel_o` 0. Simultaneous `cpu_we_i` and `cpu_oe_i` to IRQ_EN with data 8'hA5 → `cpu_data_o` shows 8'hA5 after the edge.

Source files
------------

// File: rtl/cc3_irq_pkg.sv
// cc3_irq_pkg: shared constants for the cc3 interrupt controller.
//   Register window offsets, register reset values, source count and timer width.
package cc3_irq_pkg;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned TMR_W   = 16;

  localparam logic [2:0] OFF_PEND    = 3'd0;
  localparam logic [2:0] OFF_IRQ_EN  = 3'd1;
  localparam logic [2:0] OFF_FIRQ_EN = 3'd2;
  localparam logic [2:0] OFF_EDGE    = 3'd3;
  localparam logic [2:0] OFF_TMR_LO  = 3'd4;
  localparam logic [2:0] OFF_TMR_HI  = 3'd5;
  localparam logic [2:0] OFF_TMR_CTL = 3'd6;
  localparam logic [2:0] OFF_NMI_CTL = 3'd7;

  localparam logic [7:0]       REG_RST = 8'h00;
  localparam logic [TMR_W-1:0] TMR_RST = '0;

endpackage

// File: rtl/cc3_irq_if.sv
// cc3_irq_if: byte-wide CPU bus bundle for the interrupt controller register window.
//   addr/wdata/we/oe driven by the CPU side (master), rdata/sel returned by the slave.
interface cc3_irq_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        oe;
  logic [7:0]  rdata;
  logic        sel;

  modport master (output addr, output wdata, output we, output oe, input rdata, input sel);
  modport slave  (input addr, input wdata, input we, input oe, output rdata, output sel);
endinterface

// File: rtl/cc3_irq_timer.sv
// cc3_irq_timer: periodic 16-bit down-counter for the interrupt controller.
//   clk/rst   : clock, synchronous active-high reset
//   run_i     : RUN bit; a 0->1 transition loads the counter
//   reload_i  : reload value, sampled whenever the counter reloads
//   evt_o     : one-cycle event pulse, period reload+1 cycles; reload 0 halts
module cc3_irq_timer
  import cc3_irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [TMR_W-1:0] reload_i,
  output logic             evt_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             run_prev_q, run_prev_d;
  logic             evt_q, evt_d;

  // Count down while running; at zero emit an event and reload
  always_comb begin
    cnt_d      = cnt_q;
    evt_d      = 1'b0;
    run_prev_d = run_i;
    if (run_i && !run_prev_q) begin
      cnt_d = reload_i;
    end else if (run_i) begin
      if (cnt_q == TMR_RST) begin
        if (reload_i != TMR_RST) begin
          evt_d = 1'b1;
          cnt_d = reload_i;
        end
      end else begin
        cnt_d = cnt_q - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= TMR_RST;
      run_prev_q <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_prev_q <= run_prev_d;
      evt_q      <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/cc3_irq_ctrl.sv
// cc3_irq_ctrl: interrupt controller driving the MC6809 IRQ, FIRQ and NMI inputs.
//   clk32_i/cpu_reset : clock, synchronous active-high reset
//   cpu_addr_i/cpu_data_i/cpu_we_i/cpu_oe_i : CPU bus, 8-byte window at BASE_ADDR
//   cpu_data_o/sel_o  : registered read data and its select flag
//   irq_src_i/nmi_src_i : asynchronous active-high sources
//   cpu_irq_n/cpu_firq_n/cpu_nmi_n : registered active-low requests
//   Macro CC3_IRQ_TIMER_EN adds the periodic timer feeding PEND[7].
module cc3_irq_ctrl
  import cc3_irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR        = 16'hFF90,
  parameter int unsigned NMI_PULSE_CYCLES = 4
) (
  input  logic               clk32_i,
  input  logic               cpu_reset,
  input  logic [15:0]        cpu_addr_i,
  input  logic [7:0]         cpu_data_i,
  input  logic               cpu_we_i,
  input  logic               cpu_oe_i,
  output logic [7:0]         cpu_data_o,
  output logic               sel_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               nmi_src_i,
  output logic               cpu_irq_n,
  output logic               cpu_firq_n,
  output logic               cpu_nmi_n
);

  localparam int unsigned NMI_CW = $clog2(NMI_PULSE_CYCLES + 1);

  // Bit NUM_SRC of the conditioning chain carries the NMI source
  logic [NUM_SRC:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_SRC-1:0] src_pend_q, src_pend_d;
  logic [7:0]         irq_en_q, irq_en_d, firq_en_q, firq_en_d, edge_q, edge_d;
  logic               arm_q, arm_d;
  logic [NMI_CW-1:0]  nmi_cnt_q, nmi_cnt_d;
  logic               irq_n_q, irq_n_d, firq_n_q, firq_n_d, nmi_n_q, nmi_n_d;
  logic [7:0]         data_q, data_d;
  logic               sel_q, sel_d;

  logic               hit, wr, rd;
  logic [2:0]         off;
  logic [NUM_SRC-1:0] rise, w1c, pend_cur, pend_nxt;
  logic [7:0]         rmux;
  logic               nmi_rise;

`ifdef CC3_IRQ_TIMER_EN
  logic [7:0] tmr_lo_q, tmr_lo_d, tmr_hi_q, tmr_hi_d;
  logic       run_q, run_d, tmr_pend_q, tmr_pend_d, tmr_evt;

  cc3_irq_timer u_timer (
    .clk      (clk32_i),
    .rst      (cpu_reset),
    .run_i    (run_q),
    .reload_i ({tmr_hi_q, tmr_lo_q}),
    .evt_o    (tmr_evt)
  );
`endif

  // Register file, pending latches, request and NMI pulse generation
  always_comb begin
    sync1_d   = {nmi_src_i, irq_src_i};
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    hit       = (cpu_addr_i[15:3] == BASE_ADDR[15:3]);
    wr        = hit && cpu_we_i;
    rd        = hit && cpu_oe_i;
    off       = cpu_addr_i[2:0];
    irq_en_d  = irq_en_q;
    firq_en_d = firq_en_q;
    edge_d    = edge_q;
    arm_d     = arm_q;
    w1c       = '0;
    if (wr) begin
      case (off)
        OFF_PEND:    w1c       = cpu_data_i;
        OFF_IRQ_EN:  irq_en_d  = cpu_data_i;
        OFF_FIRQ_EN: firq_en_d = cpu_data_i;
        OFF_EDGE:    edge_d    = cpu_data_i;
        OFF_NMI_CTL: arm_d     = arm_q | cpu_data_i[0];
        default:     ;
      endcase
    end

    // Level bits follow the source; edge bits latch, set beats W1C; entering edge mode clears
    rise = sync2_q[NUM_SRC-1:0] & ~prev_q[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_d[i] && !edge_q[i])
        src_pend_d[i] = 1'b0;
      else if (edge_d[i])
        src_pend_d[i] = (src_pend_q[i] & ~w1c[i]) | rise[i];
      else
        src_pend_d[i] = sync2_q[i];
    end

`ifdef CC3_IRQ_TIMER_EN
    tmr_lo_d = tmr_lo_q;
    tmr_hi_d = tmr_hi_q;
    run_d    = run_q;
    if (wr && off == OFF_TMR_LO)  tmr_lo_d = cpu_data_i;
    if (wr && off == OFF_TMR_HI)  tmr_hi_d = cpu_data_i;
    if (wr && off == OFF_TMR_CTL) run_d    = cpu_data_i[0];
    // Timer events latch regardless of bit 7's EDGE setting
    tmr_pend_d = (tmr_pend_q & ~w1c[7]) | tmr_evt;
    pend_cur   = src_pend_q | {tmr_pend_q, 7'b0};
    pend_nxt   = src_pend_d | {tmr_pend_d, 7'b0};
`else
    pend_cur   = src_pend_q;
    pend_nxt   = src_pend_d;
`endif

    irq_n_d  = ~|(pend_cur & irq_en_q);
    firq_n_d = ~|(pend_cur & firq_en_q);

    // NMI pulse: armed rising edges start a countdown; edges mid-pulse are dropped
    nmi_rise  = sync2_q[NUM_SRC] && !prev_q[NUM_SRC] && arm_q;
    nmi_cnt_d = nmi_cnt_q;
    if (nmi_cnt_q != '0)
      nmi_cnt_d = nmi_cnt_q - NMI_CW'(1);
    else if (nmi_rise)
      nmi_cnt_d = NMI_CW'(NMI_PULSE_CYCLES);
    nmi_n_d = (nmi_cnt_q == '0);

    // Read returns post-write state so a combined write/read shows the new value
    case (off)
      OFF_PEND:    rmux = pend_nxt;
      OFF_IRQ_EN:  rmux = irq_en_d;
      OFF_FIRQ_EN: rmux = firq_en_d;
      OFF_EDGE:    rmux = edge_d;
`ifdef CC3_IRQ_TIMER_EN
      OFF_TMR_LO:  rmux = tmr_lo_d;
      OFF_TMR_HI:  rmux = tmr_hi_d;
      OFF_TMR_CTL: rmux = {7'b0, run_d};
`endif
      OFF_NMI_CTL: rmux = {7'b0, arm_d};
      default:     rmux = REG_RST;
    endcase
    data_d = rd ? rmux : REG_RST;
    sel_d  = rd;
  end

  always_ff @(posedge clk32_i) begin
    if (cpu_reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      src_pend_q <= '0;
      irq_en_q   <= REG_RST;
      firq_en_q  <= REG_RST;
      edge_q     <= REG_RST;
      arm_q      <= 1'b0;
      nmi_cnt_q  <= '0;
      irq_n_q    <= 1'b1;
      firq_n_q   <= 1'b1;
      nmi_n_q    <= 1'b1;
      data_q     <= REG_RST;
      sel_q      <= 1'b0;
`ifdef CC3_IRQ_TIMER_EN
      tmr_lo_q   <= REG_RST;
      tmr_hi_q   <= REG_RST;
      run_q      <= 1'b0;
      tmr_pend_q <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      src_pend_q <= src_pend_d;
      irq_en_q   <= irq_en_d;
      firq_en_q  <= firq_en_d;
      edge_q     <= edge_d;
      arm_q      <= arm_d;
      nmi_cnt_q  <= nmi_cnt_d;
      irq_n_q    <= irq_n_d;
      firq_n_q   <= firq_n_d;
      nmi_n_q    <= nmi_n_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
`ifdef CC3_IRQ_TIMER_EN
      tmr_lo_q   <= tmr_lo_d;
      tmr_hi_q   <= tmr_hi_d;
      run_q      <= run_d;
      tmr_pend_q <= tmr_pend_d;
`endif
    end
  end

  assign cpu_data_o = data_q;
  assign sel_o      = sel_q;
  assign cpu_irq_n  = irq_n_q;
  assign cpu_firq_n = firq_n_q;
  assign cpu_nmi_n  = nmi_n_q;

endmodule

// File: tb/tb_cc3_irq_ctrl.sv
// tb_cc3_irq_ctrl: directed scoreboard bench for cc3_irq_ctrl.
//   Reads push expected data into a queue; a negedge monitor pops on sel_o.
//   Honors CC3_IRQ_TIMER_EN to pick the timer or no-timer checks.
module tb_cc3_irq_ctrl;
  import cc3_irq_pkg::*;

  localparam logic [15:0] BASE = 16'hFF90;

  typedef struct {
    logic [2:0] off;
    logic [7:0] exp;
  } rd_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_src = '0;
  logic       nmi_src = 1'b0;
  logic       irq_n, firq_n, nmi_n;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         tick_cnt = 0;
  rd_exp_t    exp_q[$];

  cc3_irq_if bus ();

  cc3_irq_ctrl #(.BASE_ADDR(BASE), .NMI_PULSE_CYCLES(4)) dut (
    .clk32_i    (clk),
    .cpu_reset  (rst),
    .cpu_addr_i (bus.addr),
    .cpu_data_i (bus.wdata),
    .cpu_we_i   (bus.we),
    .cpu_oe_i   (bus.oe),
    .cpu_data_o (bus.rdata),
    .sel_o      (bus.sel),
    .irq_src_i  (irq_src),
    .nmi_src_i  (nmi_src),
    .cpu_irq_n  (irq_n),
    .cpu_firq_n (firq_n),
    .cpu_nmi_n  (nmi_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tick_cnt++;
  endtask

  // Monitor: every cycle the DUT claims the bus, pop and compare read data
  always @(negedge clk) begin
    if (!rst && bus.sel === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sel", 32'(bus.sel), 32'(0));
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("read_off%0d", e.off), 32'(bus.rdata), 32'(e.exp));
      end
    end
  end

  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    bus.addr  = BASE + 16'(off);
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.addr  = 16'h0000;
  endtask

  task automatic bus_read(input logic [2:0] off, input logic [7:0] exp);
    rd_exp_t e;
    e.off = off;
    e.exp = exp;
    exp_q.push_back(e);
    bus.addr = BASE + 16'(off);
    bus.oe   = 1'b1;
    tick();
    bus.oe   = 1'b0;
    bus.addr = 16'h0000;
  endtask

  task automatic bus_rw(input logic [2:0] off, input logic [7:0] d, input logic [7:0] exp);
    rd_exp_t e;
    e.off = off;
    e.exp = exp;
    exp_q.push_back(e);
    bus.addr  = BASE + 16'(off);
    bus.wdata = d;
    bus.we    = 1'b1;
    bus.oe    = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.oe    = 1'b0;
    bus.addr  = 16'h0000;
  endtask

  // Bounded wait for cpu_irq_n to reach a level; returns the tick it was seen
  task automatic wait_irq(input logic val, input int budget, input string name, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (irq_n == val) begin
        t = tick_cnt;
        break;
      end
    end
    if (t < 0) chk({name, "_timeout"}, 32'(1), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tx;
    bus.addr  = 16'h0000;
    bus.wdata = 8'h00;
    bus.we    = 1'b0;
    bus.oe    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_irq_n", 32'(irq_n), 32'(1));
    chk("rst_firq_n", 32'(firq_n), 32'(1));
    chk("rst_nmi_n", 32'(nmi_n), 32'(1));
    chk("rst_sel", 32'(bus.sel), 32'(0));
    chk("rst_data", 32'(bus.rdata), 32'(0));
    for (int o = 0; o < 8; o++) bus_read(3'(o), 8'h00);

    // Level IRQ on source 0: low 3 edges after rise, high 3 edges after fall
    bus_write(OFF_IRQ_EN, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      irq_src[0] = (i <= 10);
      tick();
      chk($sformatf("lvl_irq_n_t%0d", i), 32'(irq_n), 32'(!(i >= 4 && i <= 13)));
      chk($sformatf("lvl_firq_n_t%0d", i), 32'(firq_n), 32'(1));
    end
    // W1C has no effect on a level bit
    irq_src[0] = 1'b1;
    repeat (4) tick();
    bus_write(OFF_PEND, 8'h01);
    bus_read(OFF_PEND, 8'h01);
    irq_src[0] = 1'b0;
    repeat (4) tick();

    // Edge FIRQ on source 2
    bus_write(OFF_EDGE, 8'h04);
    bus_write(OFF_FIRQ_EN, 8'h04);
    irq_src[2] = 1'b1;
    tick();
    irq_src[2] = 1'b0;
    repeat (3) tick();
    chk("edge_firq_low", 32'(firq_n), 32'(0));
    repeat (3) tick();
    chk("edge_firq_held", 32'(firq_n), 32'(0));
    chk("edge_irq_idle", 32'(irq_n), 32'(1));
    bus_read(OFF_PEND, 8'h04);
    bus_write(OFF_PEND, 8'h04);
    chk("w1c_firq_same_edge", 32'(firq_n), 32'(0));
    tick();
    chk("w1c_firq_next_edge", 32'(firq_n), 32'(1));
    bus_read(OFF_PEND, 8'h00);
    // W1C in the cycle the edge is detected: set wins
    irq_src[2] = 1'b1;
    tick();
    irq_src[2] = 1'b0;
    tick();
    bus_write(OFF_PEND, 8'h04);
    bus_read(OFF_PEND, 8'h04);
    chk("set_wins_firq", 32'(firq_n), 32'(0));
    bus_write(OFF_PEND, 8'h04);
    repeat (2) tick();
    chk("firq_cleared", 32'(firq_n), 32'(1));

    // NMI ignored while unarmed
    nmi_src = 1'b1;
    tick();
    nmi_src = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("nmi_unarmed_t%0d", i), 32'(nmi_n), 32'(1));
    end
    bus_write(OFF_NMI_CTL, 8'h01);
    bus_write(OFF_NMI_CTL, 8'h00);
    bus_read(OFF_NMI_CTL, 8'h01);
    // Armed: 4-cycle pulse; second edge during the pulse is dropped
    for (int i = 1; i <= 16; i++) begin
      nmi_src = (i == 1 || i == 4);
      tick();
      chk($sformatf("nmi_pulse_t%0d", i), 32'(nmi_n), 32'(!(i >= 4 && i <= 7)));
    end

    // Bus: out of window read, combined write/read
    bus.addr = BASE + 16'd8;
    bus.oe   = 1'b1;
    tick();
    bus.oe   = 1'b0;
    bus.addr = 16'h0000;
    chk("oow_sel", 32'(bus.sel), 32'(0));
    chk("oow_data", 32'(bus.rdata), 32'(0));
    bus_rw(OFF_IRQ_EN, 8'hA5, 8'hA5);
    bus_read(OFF_FIRQ_EN, 8'h04);
    bus_write(OFF_IRQ_EN, 8'h00);

`ifdef CC3_IRQ_TIMER_EN
    // Timer reload 9: PEND[7] every 10 cycles
    bus_write(OFF_IRQ_EN, 8'h80);
    bus_write(OFF_EDGE, 8'h80);
    bus_write(OFF_TMR_LO, 8'd9);
    bus_write(OFF_TMR_HI, 8'd0);
    bus_read(OFF_TMR_LO, 8'd9);
    bus_write(OFF_TMR_CTL, 8'h01);
    wait_irq(1'b0, 40, "tmr_first", t0);
    bus_write(OFF_PEND, 8'h80);
    wait_irq(1'b1, 5, "tmr_clear", tx);
    wait_irq(1'b0, 40, "tmr_second", t1);
    chk("tmr_period", 32'(t1 - t0), 32'(10));
    bus_read(OFF_PEND, 8'h80);
    // Reload 0: halted, no events
    bus_write(OFF_TMR_CTL, 8'h00);
    bus_write(OFF_TMR_LO, 8'h00);
    repeat (3) tick();
    bus_write(OFF_PEND, 8'h80);
    bus_write(OFF_TMR_CTL, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      repeat (5) tick();
      chk($sformatf("tmr_halt_irq_t%0d", i), 32'(irq_n), 32'(1));
    end
    bus_read(OFF_PEND, 8'h00);
    bus_write(OFF_TMR_CTL, 8'h00);
    bus_write(OFF_IRQ_EN, 8'h00);
`else
    bus_write(OFF_TMR_LO, 8'hFF);
    bus_read(OFF_TMR_LO, 8'h00);
    bus_write(OFF_TMR_CTL, 8'hFF);
    bus_read(OFF_TMR_CTL, 8'h00);
`endif

    // Reset mid-pulse aborts the NMI pulse and clears ARM
    nmi_src = 1'b1;
    tick();
    nmi_src = 1'b0;
    repeat (3) tick();
    chk("mid_pulse_low", 32'(nmi_n), 32'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("mid_pulse_reset_nmi_n", 32'(nmi_n), 32'(1));
    rst = 1'b0;
    tick();
    bus_read(OFF_NMI_CTL, 8'h00);

    repeat (2) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
